// File: rtl/hit_injector_rl_if.sv
// ---------------------------------------------------------------------------
// hit_injector_rl_if : slow-control config in, synthetic layer hits and status out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hit_injector_rl_if;
  logic        start;
  logic        abort;
  logic        mode;
  logic [5:0]  layer_mask;
  logic [17:0] layer_delay;
  logic [2:0]  hold;
  logic [3:0]  n_pulse;
  logic [3:0]  gap;
  logic [2:0]  ly0;
  logic [1:0]  ly1;
  logic        ly2;
  logic [1:0]  ly3;
  logic [2:0]  ly4;
  logic [2:0]  ly5;
  logic        busy;
  logic        done;
  logic [2:0]  exp_hits;
  logic [1:0]  exp_q;

  modport master (
    output start, abort, mode, layer_mask, layer_delay, hold, n_pulse, gap,
    input  ly0, ly1, ly2, ly3, ly4, ly5, busy, done, exp_hits, exp_q
  );

  modport slave (
    input  start, abort, mode, layer_mask, layer_delay, hold, n_pulse, gap,
    output ly0, ly1, ly2, ly3, ly4, ly5, busy, done, exp_hits, exp_q
  );
endinterface

`default_nettype wire

// File: rtl/hit_injector_rl.sv
// ---------------------------------------------------------------------------
// hit_injector_rl : test-pattern transmitter emulating a muon crossing six layers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hit_injector_rl (
  input  logic             clk,
  input  logic             rst_n,
  hit_injector_rl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_mode;
  logic [5:0]  r_mask;
  logic [17:0] r_delay;
  logic [2:0]  r_hold;
  logic [3:0]  r_npulse;
  logic [3:0]  r_gap;
  logic [3:0]  r_cnt;
  logic [3:0]  r_pc;
  logic [3:0]  r_gcnt;
  logic [13:0] r_ly;
  logic        r_busy;
  logic        r_done;
  logic [2:0]  r_exp_hits;
  logic [1:0]  r_exp_q;

  function automatic logic [5:0] f_hits(input logic [5:0] m, input logic [17:0] d,
                                        input logic [2:0] h, input logic [3:0] c);
    logic [4:0] lo;
    logic [4:0] hi;
    logic [5:0] v;
    v = '0;
    for (int i = 0; i < 6; i++) begin
      lo   = {2'b00, d[3*i +: 3]};
      hi   = lo + {2'b00, h};
      v[i] = m[i] && ({1'b0, c} >= lo) && ({1'b0, c} <= hi);
    end
    return v;
  endfunction

  // Burst length is set by the latest enabled layer; at most 7+7 = 14
  function automatic logic [3:0] f_end(input logic [5:0] m, input logic [17:0] d,
                                       input logic [2:0] h);
    logic [2:0] mx;
    mx = '0;
    for (int i = 0; i < 6; i++) begin
      if (m[i] && (d[3*i +: 3] > mx)) mx = d[3*i +: 3];
    end
    return {1'b0, mx} + {1'b0, h};
  endfunction

  // Packed as {ly0, ly1, ly2, ly3, ly4, ly5}
  function automatic logic [13:0] f_map(input logic md, input logic [5:0] v);
    logic [2:0] l0;
    logic [1:0] l1;
    logic       l2;
    logic [1:0] l3;
    logic [2:0] l4;
    logic [2:0] l5;
    l0 = '0; l1 = '0; l3 = '0; l4 = '0; l5 = '0;
    l2 = v[2];
    if (md) begin
      l0[2] = v[0]; l1[1] = v[1]; l3[0] = v[3]; l4[0] = v[4]; l5[0] = v[5];
    end else begin
      l0[0] = v[0]; l1[0] = v[1]; l3[1] = v[3]; l4[2] = v[4]; l5[2] = v[5];
    end
    return {l0, l1, l2, l3, l4, l5};
  endfunction

  logic [3:0]  w_end;
  logic [3:0]  w_cnt_inc;
  logic [13:0] w_launch_ly;
  logic [13:0] w_restart_ly;
  logic [13:0] w_step_ly;
  logic [2:0]  w_pop;
  logic [2:0]  w_pop_m3;
  logic [1:0]  w_q;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 6; i++) w_pop = w_pop + {2'b00, bus.layer_mask[i]};
  end

  assign w_pop_m3     = w_pop - 3'd3;
  assign w_q          = (w_pop >= 3'd3) ? w_pop_m3[1:0] : 2'b00;
  assign w_end        = f_end(r_mask, r_delay, r_hold);
  assign w_cnt_inc    = r_cnt + 4'd1;
  assign w_launch_ly  = f_map(bus.mode, f_hits(bus.layer_mask, bus.layer_delay, bus.hold, 4'd0));
  assign w_restart_ly = f_map(r_mode, f_hits(r_mask, r_delay, r_hold, 4'd0));
  assign w_step_ly    = f_map(r_mode, f_hits(r_mask, r_delay, r_hold, w_cnt_inc));

  // Hit registers hold the value for the cnt being loaded on this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_mask     <= '0;
      r_delay    <= '0;
      r_hold     <= '0;
      r_npulse   <= '0;
      r_gap      <= '0;
      r_cnt      <= '0;
      r_pc       <= '0;
      r_gcnt     <= '0;
      r_ly       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_exp_hits <= '0;
      r_exp_q    <= '0;
    end else begin
      r_done <= 1'b0;
      r_ly   <= '0;
      if (bus.abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_mode     <= bus.mode;
              r_mask     <= bus.layer_mask;
              r_delay    <= bus.layer_delay;
              r_hold     <= bus.hold;
              r_npulse   <= bus.n_pulse;
              r_gap      <= bus.gap;
              r_exp_hits <= w_pop;
              r_exp_q    <= w_q;
              r_pc       <= '0;
              r_cnt      <= '0;
              if (bus.layer_mask == 6'd0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_RUN;
                r_busy  <= 1'b1;
                r_ly    <= w_launch_ly;
              end
            end
          end
          S_RUN: begin
            if (r_cnt == w_end) begin
              if (r_pc == r_npulse) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else if (r_gap == 4'd0) begin
                r_cnt <= '0;
                r_pc  <= r_pc + 4'd1;
                r_ly  <= w_restart_ly;
              end else begin
                r_state <= S_GAP;
                r_gcnt  <= 4'd1;
              end
            end else begin
              r_cnt <= w_cnt_inc;
              r_ly  <= w_step_ly;
            end
          end
          S_GAP: begin
            if (r_gcnt == r_gap) begin
              r_state <= S_RUN;
              r_cnt   <= '0;
              r_pc    <= r_pc + 4'd1;
              r_ly    <= w_restart_ly;
            end else begin
              r_gcnt <= r_gcnt + 4'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.ly0      = r_ly[13:11];
  assign bus.ly1      = r_ly[10:9];
  assign bus.ly2      = r_ly[8];
  assign bus.ly3      = r_ly[7:6];
  assign bus.ly4      = r_ly[5:3];
  assign bus.ly5      = r_ly[2:0];
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.exp_hits = r_exp_hits;
  assign bus.exp_q    = r_exp_q;

endmodule

`default_nettype wire

// File: tb/tb_hit_injector_rl.sv
// ---------------------------------------------------------------------------
// tb_hit_injector_rl : frame-queue model of the injector plus directed bursts
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hit_injector_rl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  hit_injector_rl_if bus();

  hit_injector_rl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] dut_ly();
    return {bus.ly0, bus.ly1, bus.ly2, bus.ly3, bus.ly4, bus.ly5};
  endfunction

  // ---------------- behavioural model: one frame per cycle after the launch edge
  typedef struct packed {
    logic [13:0] ly;
    logic        busy;
    logic        done;
  } frame_t;

  frame_t     q[$];
  frame_t     cur = '0;
  logic [2:0] m_eh = '0;
  logic [1:0] m_eq = '0;

  // Bit index within {ly0,ly1,ly2,ly3,ly4,ly5} of each layer's single active wire
  int acc_pos[6] = '{13, 10, 8, 6, 3, 0};
  int col_pos[6] = '{11, 9, 8, 7, 5, 2};

  task automatic model_launch();
    int d[6];
    int mx;
    int e;
    int cnt;
    frame_t f;
    cnt = 0;
    mx  = 0;
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(bus.layer_delay[3*i +: 3]);
      if (bus.layer_mask[i]) begin
        cnt++;
        if (d[i] > mx) mx = d[i];
      end
    end
    m_eh = 3'(cnt);
    m_eq = (cnt >= 3) ? 2'(cnt - 3) : 2'd0;
    if (bus.layer_mask != 0) begin
      e = mx + int'(bus.hold);
      for (int p = 0; p <= int'(bus.n_pulse); p++) begin
        for (int c = 0; c <= e; c++) begin
          f = '0;
          f.busy = 1'b1;
          for (int i = 0; i < 6; i++)
            if (bus.layer_mask[i] && c >= d[i] && c <= d[i] + int'(bus.hold))
              f.ly[bus.mode ? acc_pos[i] : col_pos[i]] = 1'b1;
          q.push_back(f);
        end
        if (p < int'(bus.n_pulse)) begin
          for (int g = 0; g < int'(bus.gap); g++) begin
            f = '0;
            f.busy = 1'b1;
            q.push_back(f);
          end
        end
      end
    end
    f = '0;
    f.done = 1'b1;
    q.push_back(f);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cur  = '0;
      m_eh = '0;
      m_eq = '0;
    end else if (bus.abort) begin
      q.delete();
      cur = '0;
    end else if (q.size() == 0 && !cur.busy && !cur.done && bus.start) begin
      model_launch();
      cur = q.pop_front();
    end else if (q.size() != 0) begin
      cur = q.pop_front();
    end else begin
      cur = '0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_ly", {18'd0, dut_ly()}, {18'd0, cur.ly});
      chk("model_status", {25'd0, bus.busy, bus.done, bus.exp_hits, bus.exp_q},
          {25'd0, cur.busy, cur.done, m_eh, m_eq});
    end
  end

  // ---------------- directed stimulus
  task automatic run_burst(input logic md, input logic [5:0] mk, input logic [17:0] dl,
                           input logic [2:0] hd, input logic [3:0] np, input logic [3:0] gp,
                           input int poke,
                           output int busy_n, output int hit_n, output int done_n,
                           output int done_k, output logic [13:0] first_hits,
                           output logic [13:0] or_hits, output logic [31:0] pat);
    logic [13:0] w;
    @(negedge clk);
    bus.mode = md; bus.layer_mask = mk; bus.layer_delay = dl;
    bus.hold = hd; bus.n_pulse = np; bus.gap = gp; bus.start = 1'b1;
    busy_n = 0; hit_n = 0; done_n = 0; done_k = -1;
    first_hits = '0; or_hits = '0; pat = '0;
    for (int k = 1; k <= 300 && done_k < 0; k++) begin
      @(negedge clk);
      bus.start = (k == poke);
      if (k == poke) begin
        bus.layer_mask = 6'h01;
        bus.hold = 3'd0;
      end
      w = dut_ly();
      if (bus.busy) busy_n++;
      if (w != 0) begin
        hit_n++;
        if (first_hits == 0) first_hits = w;
        or_hits |= w;
        if (k < 32) pat[k] = 1'b1;
      end
      if (bus.done) begin
        done_n++;
        done_k = k;
      end
    end
    bus.start = 1'b0;
    if (done_k < 0) chk("burst_timeout", 32'd0, 32'd1);
    repeat (3) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
  endtask

  int          bn, hn, dn, dk;
  logic [13:0] fh, oh;
  logic [31:0] pt;

  initial begin
    bus.start = 0; bus.abort = 0; bus.mode = 0; bus.layer_mask = 0;
    bus.layer_delay = 0; bus.hold = 0; bus.n_pulse = 0; bus.gap = 0;
    #8;
    chk("reset_ly", {18'd0, dut_ly()}, 32'd0);
    chk("reset_status", {27'd0, bus.busy, bus.done, bus.exp_hits}, 32'd0);
    #4 rst_n = 1'b1;

    // accelerator, all layers, single-cycle hit
    run_burst(1'b1, 6'h3F, 18'd0, 3'd0, 4'd0, 4'd0, 0, bn, hn, dn, dk, fh, oh, pt);
    chk("t1_hits", {18'd0, fh}, {18'd0, 3'b100, 2'b10, 1'b1, 2'b01, 3'b001, 3'b001});
    chk("t1_hit_cycles", 32'(hn), 32'd1);
    chk("t1_done_k", 32'(dk), 32'd2);
    chk("t1_exp", {27'd0, bus.exp_hits, bus.exp_q}, {27'd0, 3'd6, 2'd3});

    // collision, staggered drift, hold 2
    run_burst(1'b0, 6'h3F, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 3'd2, 4'd0, 4'd0, 0,
              bn, hn, dn, dk, fh, oh, pt);
    chk("t2_busy_cycles", 32'(bn), 32'd8);
    chk("t2_done_once", 32'(dn), 32'd1);
    chk("t2_or_hits", {18'd0, oh}, {18'd0, 3'b001, 2'b01, 1'b1, 2'b10, 3'b100, 3'b100});
    chk("t2_pattern", pt, 32'h0000_01FE);

    // two layers only
    run_burst(1'b0, 6'h03, 18'd0, 3'd0, 4'd0, 4'd0, 0, bn, hn, dn, dk, fh, oh, pt);
    chk("t3_or_hits", {18'd0, oh}, {18'd0, 3'b001, 2'b01, 9'd0});
    chk("t3_exp", {27'd0, bus.exp_hits, bus.exp_q}, {27'd0, 3'd2, 2'd0});

    // empty mask, then start during the DONE cycle is ignored
    @(negedge clk);
    bus.layer_mask = 6'h00; bus.start = 1'b1;
    @(negedge clk);
    chk("t4_done_k1", {31'd0, bus.done}, 32'd1);
    chk("t4_no_hits", {18'd0, dut_ly()}, 32'd0);
    bus.layer_mask = 6'h3F;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t4_start_in_done_ignored", {30'd0, bus.busy, bus.done}, 32'd0);

    // three pulses with 3-cycle gaps
    run_burst(1'b1, 6'h3F, 18'd0, 3'd1, 4'd2, 4'd3, 0, bn, hn, dn, dk, fh, oh, pt);
    chk("t5_pattern", pt, 32'h0000_18C6);
    chk("t5_busy_cycles", 32'(bn), 32'd12);
    chk("t5_done", {16'(dk), 16'(dn)}, {16'd13, 16'd1});

    // back-to-back pulses
    run_burst(1'b1, 6'h3F, 18'd0, 3'd1, 4'd2, 4'd0, 0, bn, hn, dn, dk, fh, oh, pt);
    chk("t6_pattern", pt, 32'h0000_007E);
    chk("t6_done_k", 32'(dk), 32'd7);

    // start while busy, with config poked mid-burst
    run_burst(1'b1, 6'h3F, 18'd0, 3'd3, 4'd0, 4'd0, 2, bn, hn, dn, dk, fh, oh, pt);
    chk("t9_busy_cycles", 32'(bn), 32'd4);
    chk("t9_hit_cycles", 32'(hn), 32'd4);
    chk("t9_done_k", 32'(dk), 32'd5);

    // abort together with start mid-RUN
    @(negedge clk);
    bus.mode = 1'b1; bus.layer_mask = 6'h3F; bus.layer_delay = 18'd0;
    bus.hold = 3'd7; bus.n_pulse = 4'd15; bus.gap = 4'd0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t7_running", {18'd0, dut_ly()}, {18'd0, 3'b100, 2'b10, 1'b1, 2'b01, 3'b001, 3'b001});
    bus.abort = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0; bus.start = 1'b0;
    chk("t7_abort_ly", {18'd0, dut_ly()}, 32'd0);
    chk("t7_abort_status", {27'd0, bus.busy, bus.done, bus.exp_hits}, {27'd0, 2'b00, 3'd6});
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    chk("t7_no_done", 32'(dn), 32'd0);

    // asynchronous reset mid-burst
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_reset_ly", {18'd0, dut_ly()}, 32'd0);
    chk("t8_reset_status", {27'd0, bus.busy, bus.done, bus.exp_hits}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
